// File: rtl/serial_hex_loader_pkg.sv
// Shared constants and state encodings for the serial hex loader and its debug companions.
package serial_hex_loader_pkg;

    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_HASH   = 8'h23;
    localparam logic [7:0] CH_SPACE  = 8'h20;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_LF     = 8'h0A;

    typedef enum logic [1:0] {
        P_IDLE,
        P_ADDR,
        P_DATA_HI,
        P_DATA_LO
    } parse_state_t;

    typedef enum logic [2:0] {
        RX_HUNT,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_t;

endpackage

// File: rtl/serial_hex_loader_if.sv
// BRAM write port bundle driven by the hex loader.
interface serial_hex_loader_if #(
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] WrAddr;
    logic [7:0]        WrData;
    logic              WrEn;

    modport master (output WrAddr, output WrData, output WrEn);
    modport slave  (input  WrAddr, input  WrData, input  WrEn);
endinterface

// File: rtl/serial_hex_loader_rx.sv
// 8N1 UART receiver with input synchronizer; mirror of serial_tx.
module serial_rx
    import serial_hex_loader_pkg::*;
#(
    parameter int CLK_HZ = 24000000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       rx_pin,
    output logic [7:0] rbyte,
    output logic       valid,
    output logic       frame_err
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int CNT_W = $clog2(DIV + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(DIV - 1);

    logic             sync1, sync2, line_prev;
    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    // Synchronizer starts low so a line held low through reset lands in WAIT_IDLE.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            line_prev <= 1'b0;
            state     <= RX_WAIT_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rbyte     <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync1     <= rx_pin;
            sync2     <= sync1;
            line_prev <= sync2;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                RX_HUNT: begin
                    if (line_prev && !sync2) begin
                        state <= RX_START;
                        cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!sync2) begin
                            state   <= RX_DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= RX_HUNT;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL_LAST) begin
                        cnt     <= '0;
                        shift   <= {sync2, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7)
                            state <= RX_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == FULL_LAST) begin
                        cnt <= '0;
                        if (sync2) begin
                            rbyte <= shift;
                            valid <= 1'b1;
                            state <= RX_HUNT;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= RX_WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_WAIT_IDLE: begin
                    if (sync2)
                        state <= RX_HUNT;
                end
                default: state <= RX_WAIT_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/serial_hex_loader.sv
// Parses "$AAAA#DD DD ..CR" hex records from the UART and writes the bytes into BRAM.
module serial_hex_loader
    import serial_hex_loader_pkg::*;
#(
    parameter int CLK_HZ = 24000000,
    parameter int BAUD   = 115200,
    parameter int ADDR_W = 10
) (
    input  logic                       clk,
    input  logic                       RESET,
    input  logic                       RxPin,
    serial_hex_loader_if.master        bram,
    output logic                       FrameErr,
    output logic                       SyntaxErr,
    output logic                       Active
);

    logic [7:0]        rx_byte;
    logic              rx_valid;
    logic              rx_ferr;
    parse_state_t      state;
    logic [ADDR_W-1:0] acc;
    logic [3:0]        hi;
    logic [4:0]        dig;

    // Bit 4 flags a legal hex digit, bits 3:0 carry its value.
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        logic [7:0] d;
        d          = 8'h00;
        hex_decode = 5'h00;
        if (c >= 8'h30 && c <= 8'h39) begin
            d          = c - 8'h30;
            hex_decode = {1'b1, d[3:0]};
        end else if (c >= 8'h41 && c <= 8'h46) begin
            d          = c - 8'h37;
            hex_decode = {1'b1, d[3:0]};
        end else if (c >= 8'h61 && c <= 8'h66) begin
            d          = c - 8'h57;
            hex_decode = {1'b1, d[3:0]};
        end
    endfunction

    serial_rx #(
        .CLK_HZ(CLK_HZ),
        .BAUD  (BAUD)
    ) u_rx (
        .clk      (clk),
        .RESET    (RESET),
        .rx_pin   (RxPin),
        .rbyte    (rx_byte),
        .valid    (rx_valid),
        .frame_err(rx_ferr)
    );

    assign dig      = hex_decode(rx_byte);
    assign FrameErr = rx_ferr;
    assign Active   = (state != P_IDLE);

    // A frame error abandons the record silently; written bytes stay in memory.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state       <= P_IDLE;
            acc         <= '0;
            hi          <= '0;
            bram.WrAddr <= '0;
            bram.WrData <= '0;
            bram.WrEn   <= 1'b0;
            SyntaxErr   <= 1'b0;
        end else begin
            bram.WrEn <= 1'b0;
            SyntaxErr <= 1'b0;
            if (bram.WrEn)
                bram.WrAddr <= bram.WrAddr + 1'b1;
            if (rx_ferr) begin
                state <= P_IDLE;
            end else if (rx_valid) begin
                case (state)
                    P_IDLE: begin
                        if (rx_byte == CH_DOLLAR) begin
                            state <= P_ADDR;
                            acc   <= '0;
                        end
                    end
                    P_ADDR: begin
                        if (dig[4]) begin
                            acc <= ADDR_W'({acc, dig[3:0]});
                        end else if (rx_byte == CH_HASH) begin
                            bram.WrAddr <= acc;
                            state       <= P_DATA_HI;
                        end else if (rx_byte == CH_DOLLAR) begin
                            acc <= '0;
                        end else begin
                            SyntaxErr <= 1'b1;
                            state     <= P_IDLE;
                        end
                    end
                    P_DATA_HI: begin
                        if (dig[4]) begin
                            hi    <= dig[3:0];
                            state <= P_DATA_LO;
                        end else if (rx_byte == CH_SPACE) begin
                            state <= P_DATA_HI;
                        end else if (rx_byte == CH_CR || rx_byte == CH_LF) begin
                            state <= P_IDLE;
                        end else if (rx_byte == CH_DOLLAR) begin
                            acc   <= '0;
                            state <= P_ADDR;
                        end else begin
                            SyntaxErr <= 1'b1;
                            state     <= P_IDLE;
                        end
                    end
                    P_DATA_LO: begin
                        if (dig[4]) begin
                            bram.WrData <= {hi, dig[3:0]};
                            bram.WrEn   <= 1'b1;
                            state       <= P_DATA_HI;
                        end else begin
                            SyntaxErr <= 1'b1;
                            state     <= P_IDLE;
                        end
                    end
                    default: state <= P_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_hex_loader.sv
// Self-checking bench: UART-driven hex records compared against a character-level reference model.
module tb_serial_hex_loader;

    localparam int CLK_HZ    = 1600000;
    localparam int BAUD      = 100000;
    localparam int DIV       = CLK_HZ / BAUD;
    localparam int ADDR_W    = 10;
    localparam int ADDR_SPAN = 1 << ADDR_W;

    logic clk   = 1'b0;
    logic RESET = 1'b0;
    logic RxPin = 1'b1;
    logic FrameErr, SyntaxErr, Active;

    serial_hex_loader_if #(.ADDR_W(ADDR_W)) bram ();

    serial_hex_loader #(
        .CLK_HZ(CLK_HZ),
        .BAUD  (BAUD),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk      (clk),
        .RESET    (RESET),
        .RxPin    (RxPin),
        .bram     (bram),
        .FrameErr (FrameErr),
        .SyntaxErr(SyntaxErr),
        .Active   (Active)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int obsAddr[$];
    int obsData[$];
    int synCount     = 0;
    int frmCount     = 0;
    int overlapCount = 0;

    // Reference model state: mode 0 idle, 1 address, 2 high nibble, 3 low nibble.
    int mMode = 0;
    int mAcc  = 0;
    int mHi   = 0;
    int mAddr = 0;
    int expAddr[$];
    int expData[$];
    int expSyn = 0;
    int expFrm = 0;

    always @(negedge clk) begin
        if (RESET) begin
            if (bram.WrEn) begin
                obsAddr.push_back(int'(bram.WrAddr));
                obsData.push_back(int'(bram.WrData));
            end
            if (SyntaxErr) synCount++;
            if (FrameErr) frmCount++;
            if (SyntaxErr && FrameErr) overlapCount++;
        end
    end

    function automatic int hexVal(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
        if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
        return -1;
    endfunction

    function automatic logic [7:0] hexChar(input int v, input bit lower);
        if (v < 10) return 8'(48 + v);
        return lower ? 8'(87 + v) : 8'(55 + v);
    endfunction

    task automatic modelChar(input logic [7:0] c);
        int v;
        v = hexVal(c);
        case (mMode)
            0: if (c == 8'h24) begin mMode = 1; mAcc = 0; end
            1: begin
                if (v >= 0) mAcc = (mAcc * 16 + v) % ADDR_SPAN;
                else if (c == 8'h23) begin mAddr = mAcc; mMode = 2; end
                else if (c == 8'h24) mAcc = 0;
                else begin expSyn++; mMode = 0; end
            end
            2: begin
                if (v >= 0) begin mHi = v; mMode = 3; end
                else if (c == 8'h20) mMode = 2;
                else if (c == 8'h0D || c == 8'h0A) mMode = 0;
                else if (c == 8'h24) begin mMode = 1; mAcc = 0; end
                else begin expSyn++; mMode = 0; end
            end
            default: begin
                if (v >= 0) begin
                    expAddr.push_back(mAddr);
                    expData.push_back(mHi * 16 + v);
                    mAddr = (mAddr + 1) % ADDR_SPAN;
                    mMode = 2;
                end else begin
                    expSyn++;
                    mMode = 0;
                end
            end
        endcase
    endtask

    // A bad stop bit leaves the line low; the caller decides when to release it.
    task automatic sendByte(input logic [7:0] c, input bit badStop);
        @(negedge clk) RxPin = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RxPin = c[i];
            repeat (DIV) @(negedge clk);
        end
        RxPin = !badStop;
        repeat (DIV) @(negedge clk);
        if (badStop) begin
            mMode = 0;
            expFrm++;
        end else begin
            repeat (2) @(negedge clk);
            modelChar(c);
        end
    endtask

    task automatic sendString(input string s);
        for (int i = 0; i < s.len(); i++)
            sendByte(s[i], 1'b0);
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        int n;
        repeat (4) @(negedge clk);
        checkValue({tag, ".writes"}, 32'(obsAddr.size()), 32'(expAddr.size()));
        n = (obsAddr.size() < expAddr.size()) ? obsAddr.size() : expAddr.size();
        for (int i = 0; i < n; i++) begin
            checkValue($sformatf("%s.addr%0d", tag, i), 32'(obsAddr[i]), 32'(expAddr[i]));
            checkValue($sformatf("%s.data%0d", tag, i), 32'(obsData[i]), 32'(expData[i]));
        end
        checkValue({tag, ".syntaxErr"}, 32'(synCount), 32'(expSyn));
        checkValue({tag, ".frameErr"}, 32'(frmCount), 32'(expFrm));
        checkValue({tag, ".active"}, 32'(Active), 32'(mMode != 0));
        obsAddr.delete();
        obsData.delete();
        expAddr.delete();
        expData.delete();
    endtask

    // One well-formed record with random address length, case, spacing and terminator.
    task automatic applyStimulus(input int nBytes);
        string junk;
        int nJunk, nDigits;
        junk  = "xyz!?G";
        nJunk = $urandom_range(0, 2);
        for (int i = 0; i < nJunk; i++)
            sendByte(junk[$urandom_range(0, 5)], 1'b0);
        sendByte(8'h24, 1'b0);
        nDigits = $urandom_range(1, 5);
        for (int i = 0; i < nDigits; i++)
            sendByte(hexChar($urandom_range(0, 15), 1'($urandom_range(0, 1))), 1'b0);
        sendByte(8'h23, 1'b0);
        for (int b = 0; b < nBytes; b++) begin
            if (b > 0 && $urandom_range(0, 1) == 1) sendByte(8'h20, 1'b0);
            sendByte(hexChar($urandom_range(0, 15), 1'($urandom_range(0, 1))), 1'b0);
            sendByte(hexChar($urandom_range(0, 15), 1'($urandom_range(0, 1))), 1'b0);
        end
        sendByte(($urandom_range(0, 1) == 1) ? 8'h0D : 8'h0A, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        checkValue("rst.WrEn", 32'(bram.WrEn), 32'd0);
        checkValue("rst.WrAddr", 32'(bram.WrAddr), 32'd0);
        checkValue("rst.WrData", 32'(bram.WrData), 32'd0);
        checkValue("rst.FrameErr", 32'(FrameErr), 32'd0);
        checkValue("rst.SyntaxErr", 32'(SyntaxErr), 32'd0);
        checkValue("rst.Active", 32'(Active), 32'd0);
        RESET = 1'b1;
        repeat (5) @(negedge clk);

        sendString("$0010#AB CD");
        sendByte(8'h0D, 1'b0);
        checkOutput("basic");

        sendString("$03FF#11 22");
        sendByte(8'h0D, 1'b0);
        checkOutput("wrap");

        sendString("$1ABC#5e");
        sendByte(8'h0D, 1'b0);
        checkOutput("truncLower");

        sendString("$0020#A ");
        checkOutput("halfByteSpace");
        sendString("$0000#01");
        sendByte(8'h0D, 1'b0);
        checkOutput("afterSyntax");

        sendString("$99$0050#AA$0060#BB");
        sendByte(8'h0A, 1'b0);
        sendString("$12G");
        checkOutput("restartAndBadAddr");

        // Short low glitch mid-record must not produce a character.
        sendString("$0030#");
        @(negedge clk) RxPin = 1'b0;
        repeat (DIV / 4) @(negedge clk);
        RxPin = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        sendString("12");
        sendByte(8'h0D, 1'b0);
        checkOutput("glitch");

        // Bad stop bit followed by a long break.
        sendString("$0040#77 ");
        sendByte(8'h38, 1'b1);
        repeat (40 * DIV) @(negedge clk);
        RxPin = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("frameBreak");
        sendString("$0041#99");
        sendByte(8'h0D, 1'b0);
        checkOutput("recover");

        for (int r = 0; r < 6; r++) begin
            applyStimulus($urandom_range(1, 6));
            checkOutput($sformatf("rand%0d", r));
        end
        applyStimulus(16);
        checkOutput("dumpLine16");

        // Reset during the third data bit of '#', with a record in progress.
        sendString("$0155");
        @(negedge clk) RxPin = 1'b0;
        repeat (DIV) @(negedge clk);
        RxPin = 1'b1;
        repeat (DIV) @(negedge clk);
        RxPin = 1'b1;
        repeat (DIV) @(negedge clk);
        RxPin = 1'b0;
        repeat (DIV / 2) @(negedge clk);
        checkValue("preRst.Active", 32'(Active), 32'd1);
        RESET = 1'b0;
        #1;
        checkValue("midRst.WrEn", 32'(bram.WrEn), 32'd0);
        checkValue("midRst.WrAddr", 32'(bram.WrAddr), 32'd0);
        checkValue("midRst.WrData", 32'(bram.WrData), 32'd0);
        checkValue("midRst.FrameErr", 32'(FrameErr), 32'd0);
        checkValue("midRst.SyntaxErr", 32'(SyntaxErr), 32'd0);
        checkValue("midRst.Active", 32'(Active), 32'd0);
        RxPin = 1'b1;
        mMode = 0;
        mAcc  = 0;
        mAddr = 0;
        repeat (3) @(negedge clk);
        RESET = 1'b1;
        repeat (5) @(negedge clk);
        sendString("$0123#C3");
        sendByte(8'h0D, 1'b0);
        checkOutput("postReset");

        checkValue("errOverlap", 32'(overlapCount), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_hex_loader.md
# serial_hex_loader

UART receive and hex-record parser that writes bytes into the block RAM used by the serial dump path. It is the upstream counterpart of the `$AAAA#DD DD ...CR` dump format, so a captured dump can be replayed back into memory unchanged. It sits between the board RX pin and the BRAM write port (`AD`/`DI`/`WRE`). It runs on the 24 MHz board clock.

## Interface
- `CLK_HZ`, 24000000: input clock frequency.
- `BAUD`, 115200: line rate, fixed at 8 data bits, no parity, 1 stop bit.
- `ADDR_W`, 10: BRAM word-address width.
- `clk  in  1`: system clock.
- `RESET  in  1`: reset, asynchronous, active-low. Low clears all state immediately.
- `RxPin  in  1`: UART line, idle high, asynchronous to `clk`.
- `WrAddr  out  ADDR_W`: write address. Reset value 0.
- `WrData  out  8`: write data. Reset value 0.
- `WrEn  out  1`: one-cycle write strobe. Reset value 0.
- `FrameErr  out  1`: one-cycle pulse when the stop bit samples low. Reset value 0.
- `SyntaxErr  out  1`: one-cycle pulse on an illegal character in a record. Reset value 0.
- `Active  out  1`: high while the parser is inside a record (any state other than IDLE). Reset value 0.

## Operation
- **Receiver timing**
  - `DIV = CLK_HZ/BAUD`, truncated (208 at the defaults).
  - `RxPin` passes through a 2-flop synchronizer, then falling-edge detect.
- **Receiver states**
  - HUNT: wait for a falling edge.
  - START: wait `DIV/2` (104) cycles. If the line is still low, go to DATA. Otherwise return to HUNT as a glitch; no error is flagged.
  - DATA: sample every `DIV` cycles, 8 bits, LSB first.
  - STOP: sample after `DIV` more cycles.
    - High: emit `rx_valid` with the byte.
    - Low: pulse `FrameErr`, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until the synchronized line is high, then HUNT. This covers a break condition.
- **Parser states**: IDLE, ADDR, DATA_HI, DATA_LO. Parsing is driven only by `rx_valid`.
- **Hex digits**: `0-9`, `A-F`, `a-f`.
- **IDLE**
  - `$` → ADDR, address accumulator cleared.
  - Everything else is ignored.
- **ADDR**
  - Hex digit: `acc <= {acc, digit}` truncated to `ADDR_W` bits. Any number of digits is accepted; the low `ADDR_W` bits win.
  - `#`: `WrAddr <= acc`, go to DATA_HI.
  - `$`: clear the accumulator, stay in ADDR.
  - Other character: pulse `SyntaxErr`, go to IDLE.
- **DATA_HI**
  - Hex digit: latch the high nibble, go to DATA_LO.
  - Space: stay.
  - CR (13) or LF (10): go to IDLE.
  - `$`: go to ADDR with the accumulator cleared.
  - Other character: pulse `SyntaxErr`, go to IDLE.
- **DATA_LO**
  - Hex digit: `WrData <= {hi, digit}`, `WrEn` pulses, go to DATA_HI.
  - Any other character, including space and CR: pulse `SyntaxErr`, drop the half byte, go to IDLE.
- **Address increment**
  - `WrAddr` increments by 1 after every write.
  - It wraps from `2^ADDR_W-1` to 0 silently.
- **Frame error inside a record**: the parser aborts to IDLE. No `SyntaxErr` is raised. Bytes already written stay written.

## Timing
- `rx_valid` asserts 1 cycle at the stop-bit sample point, about 9.5 bit periods after the start edge plus 2 synchronizer cycles.
- `WrEn`, `SyntaxErr` and state changes register on the cycle after `rx_valid`. Parser latency is 1 cycle.
- `WrAddr` and `WrData` are stable during `WrEn`. `WrAddr` advances on the cycle after `WrEn`.
- The maximum write rate is 1 per 2 received characters, so there is no backpressure and no FIFO is needed.
- `FrameErr` and `SyntaxErr` are never asserted in the same cycle. `FrameErr` comes from the receiver; `SyntaxErr` comes from the parser on the following cycle.
- Reset asserted mid-byte or mid-record: all outputs go to their reset values immediately. After release, the receiver starts in HUNT (WAIT_IDLE if the line is low) and the parser starts in IDLE.

## Structure
- **Shared package**
  - ASCII constants: `$`=0x24, `#`=0x23, space=0x20, CR=0x0D, LF=0x0A.
  - Parser state encoding.
  - The same package is used by `serialdebug` for its stage characters.
- **Sub-module**: `serial_rx` (receiver plus synchronizer; outputs `rbyte`, `valid`, `frame_err`), the mirror of `serial_tx`.
- **Top**: hex decode function and parser FSM.

## Test plan
- `$0010#AB CD` + CR at 115200 → two `WrEn` pulses: (0x010, 0xAB) then (0x011, 0xCD). `Active` returns to 0 after CR. No errors.
- `$03FF#11 22` + CR → writes (0x3FF, 0x11) then (0x000, 0x22), wrapping. `$1ABC#5e` + CR → write (0x2BC, 0x5E), showing address truncation and lowercase hex.
- `$0020#A` + space → `SyntaxErr` pulse, no `WrEn`, parser back in IDLE. A following `$0000#01` + CR writes (0x000, 0x01).
- A byte with the stop bit forced low in mid-record → `FrameErr` pulse, no write. Line held low for 3 ms → no further `rx_valid`. Recovery on the next valid `$` record.
- A 1 µs low glitch on an idle line → no `rx_valid`, no errors. Reset pulled low during the 3rd data bit of `#` → all outputs 0 at once. A clean record after release is processed normally.
- `BAUD` = 9600 with `CLK_HZ` = 24000000 (DIV=2500): a full round trip of a 16-byte dump line produces 16 sequential writes.
